regfile_wr_arbiter: RTL and testbench

Shares the single register-file write port (`we`/`waddr`/`wdata`) between two producers: the in-order pipeline writeback (WB) and a long-latency unit (LU: multiply/divide result return). WB has priority; LU results are buffered in a small FIFO and guaranteed a slot after a bounded wait. The block drives the regfile write port from registers and exports a pending-write mask so decode can stall on registers still queued in the FIFO.

---
 rtl/regfile_wr_arbiter_pkg.sv | 32 +++
 rtl/regfile_wr_arbiter_if.sv | 29 ++
 rtl/regfile_wr_arbiter_lu_wr_fifo.sv | 59 +++++
 rtl/regfile_wr_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_wr_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared register-file defines plus the write-port arbitration encodings.
package regfile_wr_arbiter_pkg;

  typedef logic [31:0] RegBus;
  typedef logic [4:0]  RegAddrBus;
  typedef logic [31:0] RegNum;

  localparam logic WriteEnable = 1'b1;

  // Largest wait the 3-bit age counter can express.
  localparam int unsigned ArbWaitMax = 7;

  typedef enum logic [1:0] {
    GntNone = 2'd0,
    GntWb   = 2'd1,
    GntLu   = 2'd2
  } gnt_e;

  typedef struct packed {
    RegAddrBus waddr;
    RegBus     wdata;
  } lu_entry_t;

  // One-hot register mask; r0 is hardwired and never reported as pending.
  function automatic RegNum reg_onehot(input RegAddrBus addr);
    RegNum m;
    m = '0;
    if (addr != '0) m[addr] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Producer requests and regfile write-port signals of the write arbiter.
interface regfile_wr_arbiter_if;
  import regfile_wr_arbiter_pkg::*;

  logic      wb_valid;
  logic      wb_ready;
  RegAddrBus wb_waddr;
  RegBus     wb_wdata;
  logic      lu_valid;
  logic      lu_ready;
  RegAddrBus lu_waddr;
  RegBus     lu_wdata;
  logic      we;
  RegAddrBus waddr;
  RegBus     wdata;
  RegNum     pend_mask;
  logic      lu_grant;

  modport master (
    output wb_valid, wb_waddr, wb_wdata, lu_valid, lu_waddr, lu_wdata,
    input  wb_ready, lu_ready, we, waddr, wdata, pend_mask, lu_grant
  );

  modport slave (
    input  wb_valid, wb_waddr, wb_wdata, lu_valid, lu_waddr, lu_wdata,
    output wb_ready, lu_ready, we, waddr, wdata, pend_mask, lu_grant
  );

endinterface

// File: rtl/regfile_wr_arbiter_lu_wr_fifo.sv
// Small FIFO holding long-latency results until they win the write port.
module lu_wr_fifo
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  lu_entry_t       push_data,
  input  logic            pop,
  output logic            full,
  output logic            empty,
  output lu_entry_t       head,
  output logic [DEPTH-1:0] valid,
  output lu_entry_t       slots [DEPTH]
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [DEPTH-1:0] vld;
  lu_entry_t        mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign valid   = vld;
  assign slots   = mem;

  // Pointers and per-slot valid bits; a slot's valid bit tracks occupancy for the pending mask.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      vld    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr                <= wr_ptr + 1'b1;
        vld[wr_ptr[AW-1:0]]   <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr                <= rd_ptr + 1'b1;
        vld[rd_ptr[AW-1:0]]   <= 1'b0;
      end
    end
  end

  // Entry storage; contents are only observed through valid slots.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single regfile write port between WB (priority) and queued LU results.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned LU_DEPTH = 2,
  parameter int unsigned MAX_WAIT = 3
) (
  input logic                clk,
  input logic                rst,
  regfile_wr_arbiter_if.slave bus
);

  localparam logic [2:0] WaitLimit =
    (MAX_WAIT > ArbWaitMax) ? 3'(ArbWaitMax) : 3'(MAX_WAIT);

  logic                fifo_full;
  logic                fifo_empty;
  lu_entry_t           head;
  logic [LU_DEPTH-1:0] slot_vld;
  lu_entry_t           slots [LU_DEPTH];
  lu_entry_t           lu_in;
  logic                push;
  logic                pop;
  logic                force_lu;
  logic [2:0]          age;
  gnt_e                gnt_d;
  gnt_e                gnt_q;
  logic                we_q;
  RegAddrBus           waddr_q;
  RegBus               wdata_q;
  RegNum               mask;

  assign lu_in.waddr = bus.lu_waddr;
  assign lu_in.wdata = bus.lu_wdata;
  assign push        = bus.lu_valid && !fifo_full;

  lu_wr_fifo #(.DEPTH(LU_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (lu_in),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head),
    .valid     (slot_vld),
    .slots     (slots)
  );

  assign force_lu = !fifo_empty && (age == WaitLimit);

  // Grant selection: a starved LU head beats WB, otherwise WB, otherwise drain the FIFO.
  always_comb begin
    gnt_d = GntNone;
    pop   = 1'b0;
    if (force_lu) begin
      gnt_d = GntLu;
      pop   = 1'b1;
    end else if (bus.wb_valid) begin
      gnt_d = GntWb;
    end else if (!fifo_empty) begin
      gnt_d = GntLu;
      pop   = 1'b1;
    end
  end

  // Pending mask: every queued destination is reported until its entry leaves the FIFO.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < LU_DEPTH; i++) begin
      if (slot_vld[i]) mask = mask | reg_onehot(slots[i].waddr);
    end
  end

  // Head age: counts lost arbitration cycles, saturating at the forcing threshold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age <= '0;
    end else if (pop || fifo_empty) begin
      age <= '0;
    end else if (age != WaitLimit) begin
      age <= age + 3'd1;
    end
  end

  // Registered grant and write port; r0 writes are consumed with the enable suppressed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q   <= GntNone;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      unique case (gnt_d)
        GntWb: begin
          we_q    <= WriteEnable & (bus.wb_waddr != '0);
          waddr_q <= bus.wb_waddr;
          wdata_q <= bus.wb_wdata;
        end
        GntLu: begin
          we_q    <= WriteEnable & (head.waddr != '0);
          waddr_q <= head.waddr;
          wdata_q <= head.wdata;
        end
        default: we_q <= 1'b0;
      endcase
    end
  end

  assign bus.wb_ready  = !force_lu;
  assign bus.lu_ready  = !fifo_full;
  assign bus.we        = we_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.pend_mask = mask;
  assign bus.lu_grant  = we_q && (gnt_q == GntLu);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  regfile_wr_arbiter_if bus ();

  regfile_wr_arbiter #(.LU_DEPTH(2), .MAX_WAIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected behaviour for the full-FIFO scenario, indexed by relative cycle.
  int unsigned f_pend [14] = '{32'h0, 32'h2, 32'h6, 32'h6, 32'h6, 32'h4, 32'hC,
                               32'hC, 32'hC, 32'h8, 32'h8, 32'h8, 32'h8, 32'h0};
  int unsigned f_lur  [14] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1};
  int unsigned f_wbr  [14] = '{1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 1};
  int unsigned f_addr [14] = '{0, 20, 20, 20, 20, 1, 20, 20, 20, 2, 20, 20, 20, 3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.wb_valid = v;
    bus.wb_waddr = a;
    bus.wb_wdata = d;
  endtask

  task automatic drive_lu(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.lu_valid = v;
    bus.lu_waddr = a;
    bus.lu_wdata = d;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] a,
                        input logic [31:0] d, input logic g);
    chk({tag, ".we"}, 32'(bus.we), 32'(we));
    if (we) begin
      chk({tag, ".waddr"}, 32'(bus.waddr), 32'(a));
      chk({tag, ".wdata"}, bus.wdata, d);
    end
    chk({tag, ".lu_grant"}, 32'(bus.lu_grant), 32'(g));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    drive_wb(1'b0, '0, '0);
    drive_lu(1'b0, '0, '0);

    // Reset state
    @(negedge clk);
    chk_wr("rst", 1'b0, 5'd0, 32'd0, 1'b0);
    chk("rst.waddr", 32'(bus.waddr), 32'd0);
    chk("rst.wdata", bus.wdata, 32'd0);
    chk("rst.pend", bus.pend_mask, 32'd0);
    chk("rst.lu_ready", 32'(bus.lu_ready), 32'd1);
    chk("rst.wb_ready", 32'(bus.wb_ready), 32'd1);
    #2 rst = 1'b1;

    // WB only: accepted in one cycle, written the next, for one cycle only
    step(); drive_wb(1'b1, 5'd3, 32'h1234_5678);
    @(negedge clk); chk("wb.ready", 32'(bus.wb_ready), 32'd1);
    step(); drive_wb(1'b0, '0, '0);
    @(negedge clk); chk_wr("wb.c1", 1'b1, 5'd3, 32'h1234_5678, 1'b0);
    step();
    @(negedge clk); chk_wr("wb.c2", 1'b0, 5'd0, 32'd0, 1'b0);

    // LU only: pending in N+1, written in N+2
    step(); drive_lu(1'b1, 5'd7, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("lu.c0.ready", 32'(bus.lu_ready), 32'd1);
    chk("lu.c0.pend", bus.pend_mask, 32'd0);
    step(); drive_lu(1'b0, '0, '0);
    @(negedge clk);
    chk("lu.c1.pend", bus.pend_mask, 32'h80);
    chk_wr("lu.c1", 1'b0, 5'd0, 32'd0, 1'b0);
    step();
    @(negedge clk);
    chk_wr("lu.c2", 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1);
    chk("lu.c2.pend", bus.pend_mask, 32'd0);
    step();
    @(negedge clk); chk_wr("lu.c3", 1'b0, 5'd0, 32'd0, 1'b0);

    // Starvation bound: WB saturating, LU head forced through after three lost cycles
    step(); drive_wb(1'b1, 5'd10, 32'hA0); drive_lu(1'b1, 5'd11, 32'hB0);
    @(negedge clk); chk("st.c0.wb_ready", 32'(bus.wb_ready), 32'd1);
    step(); drive_wb(1'b1, 5'd10, 32'hA1); drive_lu(1'b0, '0, '0);
    @(negedge clk);
    chk("st.c1.wb_ready", 32'(bus.wb_ready), 32'd1);
    chk("st.c1.pend", bus.pend_mask, 32'h800);
    chk_wr("st.c1", 1'b1, 5'd10, 32'hA0, 1'b0);
    step(); drive_wb(1'b1, 5'd10, 32'hA2);
    @(negedge clk);
    chk("st.c2.wb_ready", 32'(bus.wb_ready), 32'd1);
    chk_wr("st.c2", 1'b1, 5'd10, 32'hA1, 1'b0);
    step(); drive_wb(1'b1, 5'd10, 32'hA3);
    @(negedge clk);
    chk("st.c3.wb_ready", 32'(bus.wb_ready), 32'd1);
    chk_wr("st.c3", 1'b1, 5'd10, 32'hA2, 1'b0);
    step(); drive_wb(1'b1, 5'd10, 32'hA4);
    @(negedge clk);
    chk("st.c4.wb_ready", 32'(bus.wb_ready), 32'd0);
    chk_wr("st.c4", 1'b1, 5'd10, 32'hA3, 1'b0);
    step();
    @(negedge clk);
    chk("st.c5.wb_ready", 32'(bus.wb_ready), 32'd1);
    chk("st.c5.pend", bus.pend_mask, 32'd0);
    chk_wr("st.c5", 1'b1, 5'd11, 32'hB0, 1'b1);
    step(); drive_wb(1'b0, '0, '0);
    @(negedge clk); chk_wr("st.c6", 1'b1, 5'd10, 32'hA4, 1'b0);
    step();
    @(negedge clk); chk_wr("st.c7", 1'b0, 5'd0, 32'd0, 1'b0);

    // Full FIFO under saturating WB: back-pressure and in-order forced drain
    for (int c = 0; c < 14; c++) begin
      step();
      drive_wb(1'b1, 5'd20, 32'(c));
      if (c == 0)      drive_lu(1'b1, 5'd1, 32'h111);
      else if (c == 1) drive_lu(1'b1, 5'd2, 32'h222);
      else if (c <= 5) drive_lu(1'b1, 5'd3, 32'h333);
      else             drive_lu(1'b0, '0, '0);
      @(negedge clk);
      chk($sformatf("full.c%0d.lu_ready", c), 32'(bus.lu_ready), f_lur[c]);
      chk($sformatf("full.c%0d.wb_ready", c), 32'(bus.wb_ready), f_wbr[c]);
      chk($sformatf("full.c%0d.pend", c), bus.pend_mask, f_pend[c]);
      if (c > 0) begin
        if (f_addr[c] == 20)
          chk_wr($sformatf("full.c%0d", c), 1'b1, 5'd20, 32'(c - 1), 1'b0);
        else
          chk_wr($sformatf("full.c%0d", c), 1'b1, 5'(f_addr[c]), f_addr[c] * 32'h111, 1'b1);
      end
    end
    step(); drive_wb(1'b0, '0, '0);
    @(negedge clk); chk_wr("full.c14", 1'b1, 5'd20, 32'd13, 1'b0);
    step();
    @(negedge clk); chk_wr("full.c15", 1'b0, 5'd0, 32'd0, 1'b0);

    // Register 0 from both sources: consumed silently, never pending
    step(); drive_wb(1'b1, 5'd0, 32'h55); drive_lu(1'b1, 5'd0, 32'h66);
    @(negedge clk);
    chk("r0.c0.pend", bus.pend_mask, 32'd0);
    chk("r0.c0.lu_ready", 32'(bus.lu_ready), 32'd1);
    step(); drive_wb(1'b1, 5'd0, 32'h56); drive_lu(1'b1, 5'd0, 32'h67);
    @(negedge clk);
    chk("r0.c1.pend", bus.pend_mask, 32'd0);
    chk("r0.c1.we", 32'(bus.we), 32'd0);
    step(); drive_wb(1'b0, '0, '0); drive_lu(1'b0, '0, '0);
    @(negedge clk);
    chk("r0.c2.pend", bus.pend_mask, 32'd0);
    chk("r0.c2.lu_ready", 32'(bus.lu_ready), 32'd0);
    chk("r0.c2.we", 32'(bus.we), 32'd0);
    step();
    @(negedge clk);
    chk("r0.c3.lu_ready", 32'(bus.lu_ready), 32'd1);
    chk("r0.c3.we", 32'(bus.we), 32'd0);
    step();
    @(negedge clk);
    chk("r0.c4.we", 32'(bus.we), 32'd0);
    chk("r0.c4.lu_grant", 32'(bus.lu_grant), 32'd0);
    step();
    @(negedge clk); chk("r0.c5.we", 32'(bus.we), 32'd0);

    // Reset mid-queue: queued r5/r6 writes are discarded
    step(); drive_wb(1'b1, 5'd9, 32'h99); drive_lu(1'b1, 5'd5, 32'h5);
    step(); drive_lu(1'b1, 5'd6, 32'h6);
    step(); drive_lu(1'b0, '0, '0);
    @(negedge clk);
    chk("mr.pend_before", bus.pend_mask, 32'h60);
    #1 rst = 1'b0;
    drive_wb(1'b0, '0, '0);
    @(negedge clk);
    chk("mr.pend", bus.pend_mask, 32'd0);
    chk("mr.we", 32'(bus.we), 32'd0);
    chk("mr.lu_ready", 32'(bus.lu_ready), 32'd1);
    chk("mr.wb_ready", 32'(bus.wb_ready), 32'd1);
    #1 rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      @(negedge clk);
      chk($sformatf("mr.post%0d.we", c), 32'(bus.we), 32'd0);
      chk($sformatf("mr.post%0d.pend", c), bus.pend_mask, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
